// File: rtl/axi_port_protocol_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_port_protocol_checker : passive AXI4 master-port checker (stability, W beats
// vs AWLEN, outstanding accounting). Stall timeouts under AXI_CHK_TIMEOUT_EN. Rev 1.0
// ---------------------------------------------------------------------------
module axi_port_protocol_checker #(
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int MAX_OUT = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [ID_W-1:0]           AWID,
  input  logic [ADDR_W-1:0]         AWADDR,
  input  logic [LEN_W-1:0]          AWLEN,
  input  logic [2:0]                AWSIZE,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  input  logic                      AWREADY,
  input  logic [DATA_W-1:0]         WDATA,
  input  logic [DATA_W/8-1:0]       WSTRB,
  input  logic                      WLAST,
  input  logic                      WVALID,
  input  logic                      WREADY,
  input  logic [ID_W-1:0]           BID,
  input  logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ID_W-1:0]           ARID,
  input  logic [ADDR_W-1:0]         ARADDR,
  input  logic [LEN_W-1:0]          ARLEN,
  input  logic [2:0]                ARSIZE,
  input  logic [1:0]                ARBURST,
  input  logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [ID_W-1:0]           RID,
  input  logic                      RLAST,
  input  logic                      RVALID,
  input  logic                      RREADY,
  input  logic                      err_clr,
  output logic [15:0]               err_vec,
  output logic                      err_pulse,
  output logic [3:0]                err_first,
  output logic                      err_first_vld,
  output logic [$clog2(MAX_OUT):0]  wr_outstanding,
  output logic [$clog2(MAX_OUT):0]  rd_outstanding
);

  localparam int OUT_W = $clog2(MAX_OUT) + 1;
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int A_PW  = ID_W + ADDR_W + LEN_W + 5;
  localparam int W_PW  = DATA_W + DATA_W/8 + 1;
  localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUT);

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [A_PW-1:0] aw_pl, ar_pl;
  logic [W_PW-1:0] w_pl;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY && RLAST;
  assign aw_pl = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST};
  assign ar_pl = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
  assign w_pl  = {WDATA, WSTRB, WLAST};

  logic              aw_pend_q, aw_pend_d, w_pend_q, w_pend_d, ar_pend_q, ar_pend_d;
  logic [A_PW-1:0]   aw_copy_q, aw_copy_d, ar_copy_q, ar_copy_d;
  logic [W_PW-1:0]   w_copy_q, w_copy_d;
  logic [LEN_W-1:0]  fifo_mem_q [MAX_OUT];
  logic [LEN_W-1:0]  fifo_mem_d [MAX_OUT];
  logic [PTR_W-1:0]  fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [OUT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [LEN_W-1:0]  beat_q, beat_d, head;
  logic [OUT_W-1:0]  wr_out_q, wr_out_d, rd_out_q, rd_out_d;
  logic [15:0]       err_vec_q, err_vec_d, new_err;
  logic              err_pulse_q, err_pulse_d, err_first_vld_q, err_first_vld_d;
  logic [3:0]        err_first_q, err_first_d, first_idx;
  logic              push, pop;

`ifdef AXI_CHK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
  logic [TO_W-1:0] to_aw_q, to_aw_d, to_w_q, to_w_d, to_ar_q, to_ar_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // IDs on the response channels are not tracked per-ID.
  logic unused_ids;
  assign unused_ids = ^{BID, RID};

  assign head = fifo_mem_q[fifo_rd_q];

  always_comb begin
    new_err = '0;
    push    = 1'b0;
    pop     = 1'b0;
    beat_d  = beat_q;
    fifo_mem_d = fifo_mem_q;

    if (aw_pend_q && !AWVALID)              new_err[0] = 1'b1;
    else if (aw_pend_q && aw_pl != aw_copy_q) new_err[1] = 1'b1;
    if (w_pend_q && !WVALID)                new_err[2] = 1'b1;
    else if (w_pend_q && w_pl != w_copy_q)  new_err[3] = 1'b1;
    if (ar_pend_q && !ARVALID)              new_err[4] = 1'b1;
    else if (ar_pend_q && ar_pl != ar_copy_q) new_err[5] = 1'b1;

    aw_pend_d = AWVALID && !AWREADY;
    w_pend_d  = WVALID && !WREADY;
    ar_pend_d = ARVALID && !ARREADY;
    aw_copy_d = aw_pend_d ? aw_pl : aw_copy_q;
    w_copy_d  = w_pend_d  ? w_pl  : w_copy_q;
    ar_copy_d = ar_pend_d ? ar_pl : ar_copy_q;

    // Beat checks see only the FIFO contents from before this edge.
    if (w_hs) begin
      if (fifo_cnt_q == '0) begin
        new_err[8] = 1'b1;
      end else begin
        if (WLAST && beat_q < head)   new_err[6] = 1'b1;
        if (!WLAST && beat_q == head) new_err[7] = 1'b1;
        if (WLAST || beat_q == head) begin
          pop    = 1'b1;
          beat_d = '0;
        end else begin
          beat_d = beat_q + LEN_W'(1);
        end
      end
    end
    if (aw_hs) begin
      if (fifo_cnt_q == MAX_CNT) new_err[11] = 1'b1;
      else                       push = 1'b1;
    end
    if (push) fifo_mem_d[fifo_wr_q] = AWLEN;
    fifo_wr_d  = fifo_wr_q + PTR_W'(push);
    fifo_rd_d  = fifo_rd_q + PTR_W'(pop);
    fifo_cnt_d = fifo_cnt_q + OUT_W'(push) - OUT_W'(pop);

    wr_out_d = wr_out_q;
    if (b_hs && wr_out_q == '0) new_err[9] = 1'b1;
    if (aw_hs && !b_hs) begin
      if (wr_out_q == MAX_CNT) new_err[11] = 1'b1;
      else                     wr_out_d = wr_out_q + OUT_W'(1);
    end else if (b_hs && !aw_hs && wr_out_q != '0) begin
      wr_out_d = wr_out_q - OUT_W'(1);
    end

    rd_out_d = rd_out_q;
    if (r_hs && rd_out_q == '0) new_err[10] = 1'b1;
    if (ar_hs && !r_hs) begin
      if (rd_out_q == MAX_CNT) new_err[12] = 1'b1;
      else                     rd_out_d = rd_out_q + OUT_W'(1);
    end else if (r_hs && !ar_hs && rd_out_q != '0) begin
      rd_out_d = rd_out_q - OUT_W'(1);
    end

`ifdef AXI_CHK_TIMEOUT_EN
    // Counters saturate at TIMEOUT so each stall flags exactly once.
    to_aw_d = '0;
    to_w_d  = '0;
    to_ar_d = '0;
    if (AWVALID && !AWREADY) begin
      to_aw_d = (to_aw_q == TO_MAX) ? to_aw_q : to_aw_q + TO_W'(1);
      if (to_aw_q == TO_MAX - TO_W'(1)) new_err[13] = 1'b1;
    end
    if (WVALID && !WREADY) begin
      to_w_d = (to_w_q == TO_MAX) ? to_w_q : to_w_q + TO_W'(1);
      if (to_w_q == TO_MAX - TO_W'(1)) new_err[14] = 1'b1;
    end
    if (ARVALID && !ARREADY) begin
      to_ar_d = (to_ar_q == TO_MAX) ? to_ar_q : to_ar_q + TO_W'(1);
      if (to_ar_q == TO_MAX - TO_W'(1)) new_err[15] = 1'b1;
    end
`endif

    first_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (new_err[i]) first_idx = 4'(i);
    end

    err_vec_d       = (err_clr ? 16'h0000 : err_vec_q) | new_err;
    err_pulse_d     = |(new_err & ~err_vec_q);
    err_first_vld_d = (err_clr ? 1'b0 : err_first_vld_q) | (|new_err);
    err_first_d     = err_first_q;
    if ((err_clr || !err_first_vld_q) && (|new_err)) err_first_d = first_idx;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_pend_q       <= 1'b0;
      w_pend_q        <= 1'b0;
      ar_pend_q       <= 1'b0;
      aw_copy_q       <= '0;
      w_copy_q        <= '0;
      ar_copy_q       <= '0;
      fifo_mem_q      <= '{default: '0};
      fifo_rd_q       <= '0;
      fifo_wr_q       <= '0;
      fifo_cnt_q      <= '0;
      beat_q          <= '0;
      wr_out_q        <= '0;
      rd_out_q        <= '0;
      err_vec_q       <= '0;
      err_pulse_q     <= 1'b0;
      err_first_q     <= '0;
      err_first_vld_q <= 1'b0;
`ifdef AXI_CHK_TIMEOUT_EN
      to_aw_q         <= '0;
      to_w_q          <= '0;
      to_ar_q         <= '0;
`endif
    end else begin
      aw_pend_q       <= aw_pend_d;
      w_pend_q        <= w_pend_d;
      ar_pend_q       <= ar_pend_d;
      aw_copy_q       <= aw_copy_d;
      w_copy_q        <= w_copy_d;
      ar_copy_q       <= ar_copy_d;
      fifo_mem_q      <= fifo_mem_d;
      fifo_rd_q       <= fifo_rd_d;
      fifo_wr_q       <= fifo_wr_d;
      fifo_cnt_q      <= fifo_cnt_d;
      beat_q          <= beat_d;
      wr_out_q        <= wr_out_d;
      rd_out_q        <= rd_out_d;
      err_vec_q       <= err_vec_d;
      err_pulse_q     <= err_pulse_d;
      err_first_q     <= err_first_d;
      err_first_vld_q <= err_first_vld_d;
`ifdef AXI_CHK_TIMEOUT_EN
      to_aw_q         <= to_aw_d;
      to_w_q          <= to_w_d;
      to_ar_q         <= to_ar_d;
`endif
    end
  end

  assign err_vec        = err_vec_q;
  assign err_pulse      = err_pulse_q;
  assign err_first      = err_first_q;
  assign err_first_vld  = err_first_vld_q;
  assign wr_outstanding = wr_out_q;
  assign rd_outstanding = rd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_port_protocol_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi_port_protocol_checker : directed scenarios plus randomized traffic,
// checked each cycle against a queue-based reference model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_axi_port_protocol_checker;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, LEN_W = 4, MAX_OUT = 8, TIMEOUT = 16;

  logic ACLK = 1'b0;
  logic ARESET;
  logic [ID_W-1:0] AWID, BID, ARID, RID;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic [LEN_W-1:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic [1:0] AWBURST, ARBURST;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY, err_clr;
  logic [DATA_W-1:0] WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic [15:0] err_vec;
  logic err_pulse, err_first_vld;
  logic [3:0] err_first;
  logic [3:0] wr_outstanding, rd_outstanding;

  always #5 ACLK = ~ACLK;

  axi_port_protocol_checker #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
                              .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .err_clr(err_clr), .err_vec(err_vec), .err_pulse(err_pulse), .err_first(err_first),
    .err_first_vld(err_first_vld), .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit [15:0] m_vec;
  bit m_pulse, m_vld;
  bit [3:0] m_first;
  int m_wr, m_rd, beats;
  int lenq[$];
  bit aw_st, w_st, ar_st;
  logic [63:0] aw_prev, w_prev, ar_prev;
  int st_aw, st_w, st_ar;

  function automatic bit [3:0] lowest(bit [15:0] v);
    bit [3:0] r = 4'd0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  always @(posedge ACLK) begin : model
    bit [15:0] nw;
    bit full0;
    logic [63:0] awp, wp, arp;
    if (ARESET) begin
      m_vec = 0; m_pulse = 0; m_first = 0; m_vld = 0; m_wr = 0; m_rd = 0;
      lenq.delete(); beats = 0; aw_st = 0; w_st = 0; ar_st = 0;
      st_aw = 0; st_w = 0; st_ar = 0;
    end else begin
      nw  = 0;
      awp = 64'({AWID, AWADDR, AWLEN, AWSIZE, AWBURST});
      arp = 64'({ARID, ARADDR, ARLEN, ARSIZE, ARBURST});
      wp  = 64'({WDATA, WSTRB, WLAST});
      // a channel that stalled last edge must still be offered with identical payload
      if (aw_st) begin if (!AWVALID) nw[0] = 1; else if (awp != aw_prev) nw[1] = 1; end
      if (w_st)  begin if (!WVALID)  nw[2] = 1; else if (wp  != w_prev)  nw[3] = 1; end
      if (ar_st) begin if (!ARVALID) nw[4] = 1; else if (arp != ar_prev) nw[5] = 1; end
      aw_st = AWVALID && !AWREADY; aw_prev = awp;
      w_st  = WVALID && !WREADY;   w_prev  = wp;
      ar_st = ARVALID && !ARREADY; ar_prev = arp;

      full0 = (lenq.size() == MAX_OUT);
      if (WVALID && WREADY) begin
        if (lenq.size() == 0) nw[8] = 1;
        else begin
          if (WLAST && beats < lenq[0]) nw[6] = 1;
          if (!WLAST && beats == lenq[0]) nw[7] = 1;
          if (WLAST || beats == lenq[0]) begin void'(lenq.pop_front()); beats = 0; end
          else beats++;
        end
      end
      if (AWVALID && AWREADY) begin
        if (full0) nw[11] = 1; else lenq.push_back(int'(AWLEN));
      end

      if (BVALID && BREADY && m_wr == 0) nw[9] = 1;
      if (AWVALID && AWREADY && !(BVALID && BREADY)) begin
        if (m_wr == MAX_OUT) nw[11] = 1; else m_wr++;
      end else if (BVALID && BREADY && !(AWVALID && AWREADY) && m_wr > 0) m_wr--;

      if (RVALID && RREADY && RLAST && m_rd == 0) nw[10] = 1;
      if (ARVALID && ARREADY && !(RVALID && RREADY && RLAST)) begin
        if (m_rd == MAX_OUT) nw[12] = 1; else m_rd++;
      end else if (RVALID && RREADY && RLAST && !(ARVALID && ARREADY) && m_rd > 0) m_rd--;

`ifdef AXI_CHK_TIMEOUT_EN
      if (AWVALID && !AWREADY) begin
        if (st_aw < TIMEOUT) begin st_aw++; if (st_aw == TIMEOUT) nw[13] = 1; end
      end else st_aw = 0;
      if (WVALID && !WREADY) begin
        if (st_w < TIMEOUT) begin st_w++; if (st_w == TIMEOUT) nw[14] = 1; end
      end else st_w = 0;
      if (ARVALID && !ARREADY) begin
        if (st_ar < TIMEOUT) begin st_ar++; if (st_ar == TIMEOUT) nw[15] = 1; end
      end else st_ar = 0;
`endif

      m_pulse = |(nw & ~m_vec);
      if (err_clr) begin m_vec = 0; m_vld = 0; end
      if (nw != 0 && !m_vld) begin m_first = lowest(nw); m_vld = 1; end
      m_vec |= nw;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("err_vec", 32'(err_vec), 32'(m_vec));
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_first_vld", 32'(err_first_vld), 32'(m_vld));
    if (m_vld) chk("err_first", 32'(err_first), 32'(m_first));
    chk("wr_outstanding", 32'(wr_outstanding), 32'(m_wr));
    chk("rd_outstanding", 32'(rd_outstanding), 32'(m_rd));
  endtask

  task automatic step();
    @(posedge ACLK);
    @(negedge ACLK);
    compare_all();
  endtask

  task automatic idle();
    AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; WLAST = 0; BVALID = 0; BREADY = 0;
    ARVALID = 0; ARREADY = 0; RVALID = 0; RREADY = 0; RLAST = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    idle();
    ARESET = 1;
    step();
    ARESET = 0;
  endtask

  task automatic aw_hs(input int len);
    AWVALID = 1; AWREADY = 1; AWLEN = 4'(len);
    step();
    AWVALID = 0; AWREADY = 0;
  endtask

  task automatic w_beat(input bit last);
    WVALID = 1; WREADY = 1; WLAST = last; WDATA = $urandom;
    step();
    WVALID = 0; WREADY = 0; WLAST = 0;
  endtask

  int rdy_pct;

  initial begin
    AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 3'd2; AWBURST = 2'd1;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 3'd2; ARBURST = 2'd1;
    WDATA = 0; WSTRB = '1; BID = 0; RID = 0;
    idle();
    ARESET = 1;
    step();
    step();
    chk("reset_vec", 32'(err_vec), 32'h0);
    chk("reset_wr", 32'(wr_outstanding), 32'h0);
    ARESET = 0;

    // clean write: LEN=3, four beats, one response
    do_reset();
    AWADDR = 32'h40;
    aw_hs(3);
    chk("t1_wr_one", 32'(wr_outstanding), 32'd1);
    for (int i = 0; i < 4; i++) w_beat(i == 3);
    BVALID = 1; BREADY = 1; step(); BVALID = 0; BREADY = 0;
    chk("t1_vec_clean", 32'(err_vec), 32'h0);
    chk("t1_wr_zero", 32'(wr_outstanding), 32'd0);
    w_beat(1);
    chk("t1_fifo_empty", 32'(err_vec), 32'h0100);

    // AW payload change while stalled
    do_reset();
    AWVALID = 1; AWREADY = 0; AWADDR = 32'h100; AWLEN = 0; step();
    chk("t2_no_err", 32'(err_vec), 32'h0);
    AWADDR = 32'h104; step();
    chk("t2_vec", 32'(err_vec), 32'h0002);
    chk("t2_pulse", 32'(err_pulse), 32'd1);
    chk("t2_first", 32'(err_first), 32'd1);
    AWREADY = 1; step(); AWVALID = 0; AWREADY = 0;
    chk("t2_pulse_once", 32'(err_pulse), 32'd0);

    // early WLAST then missing WLAST
    do_reset();
    aw_hs(3);
    w_beat(0);
    w_beat(1);
    chk("t3_early", 32'(err_vec), 32'h0040);
    chk("t3_first6", 32'(err_first), 32'd6);
    aw_hs(0);
    w_beat(0);
    chk("t3_missing", 32'(err_vec), 32'h00C0);
    chk("t3_first_kept", 32'(err_first), 32'd6);

    // read overflow then one completion
    do_reset();
    ARVALID = 1; ARREADY = 1; ARADDR = 32'h200;
    for (int i = 0; i < 8; i++) step();
    chk("t4_rd8_noerr", 32'(err_vec), 32'h0);
    step();
    ARVALID = 0; ARREADY = 0;
    chk("t4_rd_ovf", 32'(err_vec), 32'h1000);
    chk("t4_rd_sat", 32'(rd_outstanding), 32'd8);
    RVALID = 1; RREADY = 1; RLAST = 1; step(); RVALID = 0; RREADY = 0; RLAST = 0;
    chk("t4_rd7", 32'(rd_outstanding), 32'd7);

    // B without write, then clear racing a new W_NO_AW
    do_reset();
    BVALID = 1; BREADY = 1; step(); BVALID = 0; BREADY = 0;
    chk("t5_b_no_wr", 32'(err_vec), 32'h0200);
    err_clr = 1; WVALID = 1; WREADY = 1; WLAST = 1; step();
    err_clr = 0; WVALID = 0; WREADY = 0; WLAST = 0;
    chk("t5_clr_vec", 32'(err_vec), 32'h0100);
    chk("t5_clr_first", 32'(err_first), 32'd8);
    chk("t5_clr_pulse", 32'(err_pulse), 32'd1);

    // AR stall timeout
    do_reset();
    ARVALID = 1; ARREADY = 0; ARADDR = 32'h300;
    for (int i = 0; i < 15; i++) step();
    chk("t6_before_to", 32'(err_vec), 32'h0);
    step();
`ifdef AXI_CHK_TIMEOUT_EN
    chk("t6_to_ar", 32'(err_vec), 32'h8000);
`else
    chk("t6_to_ar_off", 32'(err_vec), 32'h0);
`endif
    step();
    chk("t6_no_repulse", 32'(err_pulse), 32'd0);
    ARVALID = 0;

    // reset in the middle of a burst loses all state
    do_reset();
    aw_hs(3);
    w_beat(0);
    ARESET = 1; step(); ARESET = 0;
    chk("t7_rst_wr", 32'(wr_outstanding), 32'd0);
    chk("t7_rst_vec", 32'(err_vec), 32'h0);

    // randomized traffic in phases of varying READY pressure
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      case ((c / 250) % 4)
        0: rdy_pct = 70;
        1: rdy_pct = 25;
        2: rdy_pct = 95;
        default: rdy_pct = 3;
      endcase
      if (AWVALID && !AWREADY) begin
        if ($urandom_range(15) == 0) AWVALID = 0;
        if ($urandom_range(15) == 0) AWADDR = $urandom;
      end else begin
        AWVALID = ($urandom_range(3) == 0);
        AWID = 4'($urandom); AWADDR = $urandom; AWLEN = 4'($urandom_range(3));
        AWSIZE = 3'($urandom); AWBURST = 2'($urandom);
      end
      if (WVALID && !WREADY) begin
        if ($urandom_range(15) == 0) WVALID = 0;
        if ($urandom_range(15) == 0) WDATA = $urandom;
      end else begin
        WVALID = ($urandom_range(1) == 0);
        WDATA = $urandom; WSTRB = 4'($urandom); WLAST = ($urandom_range(2) == 0);
      end
      if (ARVALID && !ARREADY) begin
        if ($urandom_range(15) == 0) ARVALID = 0;
        if ($urandom_range(15) == 0) ARLEN = 4'($urandom);
      end else begin
        ARVALID = ($urandom_range(2) == 0);
        ARID = 4'($urandom); ARADDR = $urandom; ARLEN = 4'($urandom);
        ARSIZE = 3'($urandom); ARBURST = 2'($urandom);
      end
      AWREADY = ($urandom_range(99) < rdy_pct);
      WREADY  = ($urandom_range(99) < rdy_pct);
      ARREADY = ($urandom_range(99) < rdy_pct);
      BVALID = ($urandom_range(3) == 0); BREADY = ($urandom_range(1) == 0); BID = 4'($urandom);
      RVALID = ($urandom_range(2) == 0); RREADY = ($urandom_range(1) == 0);
      RLAST = ($urandom_range(1) == 0); RID = 4'($urandom);
      err_clr = ($urandom_range(9) == 0);
      ARESET = ($urandom_range(499) == 0);
      step();
    end
    ARESET = 0;
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
